// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the processor execution controller.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick is high in the cycle the count holds DIV-1 while enabled.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/cpu_step_ctrl.sv
// Execution controller: single-step, free-run or halt, issuing a one-cycle cpu_en.
module cpu_step_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int RUN_DIV = 25_000_000,
    parameter int CNT_W   = 16
) (
    input  logic             clk_100M,
    input  logic             rst,
    input  logic             step_pulse,
    input  logic             run_hold,
    input  logic             halt_pulse,
    input  logic             cpu_halted,
    output logic             cpu_en,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             run_led
);

    state_t state, state_nxt;
    logic   en_nxt;
    logic   halt_cond;
    logic   pre_clr;
    logic   pre_en;
    logic   pre_tick;

    // Prescaler only advances while RUN is being held; any exit discards its count.
    assign pre_en  = (state == ST_RUN);
    assign pre_clr = (state_nxt != ST_RUN);

    tick_prescaler #(
        .DIV (RUN_DIV)
    ) u_prescaler (
        .clk  (clk_100M),
        .rst  (rst),
        .clr  (pre_clr),
        .en   (pre_en),
        .tick (pre_tick)
    );

    always_comb begin
        state_nxt = state;
        en_nxt    = 1'b0;
        halt_cond = halt_pulse || cpu_halted;
        case (state)
            ST_IDLE: begin
                if (halt_cond) begin
                    state_nxt = ST_HALT;
                end else begin
                    en_nxt = step_pulse;
                    if (run_hold) state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_cond)      state_nxt = ST_HALT;
                else if (!run_hold) state_nxt = ST_IDLE;
                else                en_nxt    = pre_tick;
            end
            ST_HALT: begin
                if (halt_pulse && !cpu_halted) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cpu_en    <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state  <= state_nxt;
            cpu_en <= en_nxt;
            if (en_nxt) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    assign mode    = state;
    assign run_led = (state == ST_RUN);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl with RUN_DIV=4, CNT_W=4.
module tb_cpu_step_ctrl;

    localparam int RUN_DIV = 4;
    localparam int CNT_W   = 4;

    logic             clk_100M = 1'b0;
    logic             rst      = 1'b1;
    logic             step_pulse = 1'b0;
    logic             run_hold   = 1'b0;
    logic             halt_pulse = 1'b0;
    logic             cpu_halted = 1'b0;
    logic             cpu_en;
    logic [1:0]       mode;
    logic [CNT_W-1:0] instr_cnt;
    logic             run_led;

    cpu_step_ctrl #(.RUN_DIV(RUN_DIV), .CNT_W(CNT_W)) dut (
        .clk_100M   (clk_100M),
        .rst        (rst),
        .step_pulse (step_pulse),
        .run_hold   (run_hold),
        .halt_pulse (halt_pulse),
        .cpu_halted (cpu_halted),
        .cpu_en     (cpu_en),
        .mode       (mode),
        .instr_cnt  (instr_cnt),
        .run_led    (run_led)
    );

    always #5 clk_100M = ~clk_100M;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   model_cnt = 0;

    always @(posedge clk_100M) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every cpu_en pulse must match the next queued expectation.
    always @(negedge clk_100M) begin
        if (cpu_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_cpu_en", cyc, -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("cpu_en_cycle", cyc, e.cyc);
                chk("cpu_en_instr_cnt", int'(instr_cnt), e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_en(input int at_cyc);
        exp_t e;
        model_cnt = (model_cnt + 1) % 16;
        e.cyc = at_cyc;
        e.cnt = model_cnt;
        exp_q.push_back(e);
    endtask

    task automatic do_step();
        step_pulse = 1'b1;
        expect_en(cyc + 1);
        tick();
        step_pulse = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cpu_en"},    int'(cpu_en),    0);
        chk({tag, "_mode"},      int'(mode),      0);
        chk({tag, "_instr_cnt"}, int'(instr_cnt), 0);
        chk({tag, "_run_led"},   int'(run_led),   0);
    endtask

    initial begin
        int c;
        #2;
        chk_reset_outputs("reset");
        idle(2);
        rst = 1'b0;
        idle(2);

        // Three isolated steps
        for (int i = 0; i < 3; i++) begin
            do_step();
            chk("step_mode", int'(mode), 0);
            idle(3);
        end
        chk("step_instr_cnt", int'(instr_cnt), 3);

        // Run for 20 held cycles: enables at +5, +9, +13, +17
        c = cyc;
        run_hold = 1'b1;
        for (int k = 1; k <= 4; k++) expect_en(c + 1 + 4 * k);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) begin
                chk("run_mode", int'(mode), 1);
                chk("run_led", int'(run_led), 1);
            end
        end
        run_hold = 1'b0;
        tick();
        chk("run_release_mode", int'(mode), 0);
        chk("run_release_led", int'(run_led), 0);
        idle(8);
        chk("run_instr_cnt", int'(instr_cnt), 7);

        // Halt pulse in the cycle the prescaler holds 3 suppresses the due enable
        run_hold = 1'b1;
        idle(4);
        halt_pulse = 1'b1;
        tick();
        halt_pulse = 1'b0;
        chk("halt_mode", int'(mode), 2);
        chk("halt_cpu_en", int'(cpu_en), 0);
        idle(6);
        chk("halt_hold_mode", int'(mode), 2);
        run_hold = 1'b0;
        halt_pulse = 1'b1;
        tick();
        halt_pulse = 1'b0;
        chk("unhalt_mode", int'(mode), 0);
        idle(2);

        // cpu_halted during RUN; halt_pulse cannot leave while it stays high
        run_hold = 1'b1;
        idle(2);
        chk("run2_mode", int'(mode), 1);
        cpu_halted = 1'b1;
        tick();
        chk("cpu_halted_mode", int'(mode), 2);
        halt_pulse = 1'b1;
        tick();
        halt_pulse = 1'b0;
        chk("halt_sticky_mode", int'(mode), 2);
        step_pulse = 1'b1;
        tick();
        step_pulse = 1'b0;
        idle(6);
        chk("halt_step_instr_cnt", int'(instr_cnt), 7);
        run_hold = 1'b0;
        cpu_halted = 1'b0;
        halt_pulse = 1'b1;
        tick();
        halt_pulse = 1'b0;
        chk("unhalt2_mode", int'(mode), 0);
        idle(2);

        // 17 steps: count 7 -> 8, passing 15 -> 0 -> 1
        for (int i = 0; i < 17; i++) begin
            do_step();
            tick();
        end
        idle(2);
        chk("wrap_instr_cnt", int'(instr_cnt), 8);

        // Reset while the prescaler holds 2
        run_hold = 1'b1;
        idle(3);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("midrun_reset");
        run_hold = 1'b0;
        model_cnt = 0;
        idle(2);
        rst = 1'b0;
        idle(1);
        do_step();
        chk("post_reset_instr_cnt", int'(instr_cnt), 1);
        idle(2);

        // A fresh run after reset starts its prescaler from zero
        c = cyc;
        run_hold = 1'b1;
        expect_en(c + 1 + RUN_DIV);
        idle(RUN_DIV + 1);
        run_hold = 1'b0;
        idle(4);
        chk("post_reset_run_cnt", int'(instr_cnt), 2);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1);
    end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Execution controller for the 4-bit processor. It consumes the conditioned button outputs from the button front end: a step pulse, a held run level and a halt pulse. From these it produces a single-cycle processor clock enable (`cpu_en`) in one of three modes: single-step, free-run at a fixed rate, or halted. It also keeps a wrapping count of issued instructions for the display path.

## Interface
Parameters:
- `RUN_DIV`, default 25_000_000 — cycles between enables in RUN mode (4 Hz at 100 MHz); legal range ≥ 2.
- `CNT_W`, default 16 — width of the instruction counter.

Ports (reset rst, asynchronous, active-high; clock clk_100M):
- `clk_100M` — in, 1 — system clock, 100 MHz.
- `rst` — in, 1 — asynchronous, active-high reset.
- `step_pulse` — in, 1 — one-cycle pulse; request a single instruction.
- `run_hold` — in, 1 — level; high while the run button is held.
- `halt_pulse` — in, 1 — one-cycle pulse; enter HALT, or leave HALT.
- `cpu_halted` — in, 1 — level from the processor; a halt instruction has been executed.
- `cpu_en` — out, 1 — registered one-cycle processor clock enable.
- `mode` — out, 2 — current state: 00 IDLE, 01 RUN, 10 HALT; 11 is never driven.
- `instr_cnt` — out, CNT_W — number of `cpu_en` pulses issued, modulo 2^CNT_W.
- `run_led` — out, 1 — high while `mode` is RUN.

## Operation
- FSM states: IDLE, RUN, HALT. Reset state is IDLE.
- Priority within any state, highest first: halt entry, then run/step.
- Halt entry: from IDLE or RUN, `halt_pulse`=1 or `cpu_halted`=1 moves to HALT on the next edge. `cpu_en` is 0 on that edge.
- IDLE:
  - `step_pulse`=1 and no halt condition → `cpu_en`=1 for exactly one cycle; stay in IDLE.
  - `run_hold`=1 → RUN, prescaler cleared to 0.
  - If `step_pulse` and `run_hold` are both 1, the step is issued and the state moves to RUN.
- RUN:
  - Prescaler counts 0..RUN_DIV-1. In the cycle after it holds RUN_DIV-1, `cpu_en`=1 and the prescaler wraps to 0.
  - `step_pulse` is ignored.
  - `run_hold`=0 → IDLE, prescaler cleared. No enable is issued on the exit edge.
- HALT:
  - `cpu_en` is held at 0. `step_pulse` and `run_hold` are ignored.
  - `halt_pulse`=1 with `cpu_halted`=0 → IDLE.
  - `halt_pulse` with `cpu_halted`=1 → stay in HALT.
- Counter: `instr_cnt` increments on the same edge that sets `cpu_en`, so both change together. At 2^CNT_W-1 it wraps to 0.
- Reset mid-operation: every register returns to its reset value immediately, asynchronously. Any pending prescaler count is discarded.

## Timing
- Reset values: `cpu_en`=0, `mode`=00, `instr_cnt`=0, `run_led`=0, prescaler=0.
- Step latency: `step_pulse` high in cycle n → `cpu_en` high in cycle n+1 only, and `instr_cnt` shows +1 from n+1.
- Run cadence: `run_hold` rises in cycle n → `mode`=01 from n+1 → first `cpu_en` in cycle n+1+RUN_DIV. After that, one `cpu_en` every RUN_DIV cycles.
- Halt latency: a halt condition in cycle n → `mode`=10 from n+1. No `cpu_en` in n+1, even if the prescaler was due.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `cpu_ctrl_pkg` holds the 2-bit mode/state encodings (IDLE=2'b00, RUN=2'b01, HALT=2'b10).
- One sub-module: `tick_prescaler` (parameter DIV; inputs clk, rst, clr, en; output one-cycle tick). It is instantiated for RUN timing.
- The FSM, enable register and instruction counter live in the top level.

## Test plan
All scenarios use RUN_DIV=4 and CNT_W=4.
- Reset, then 3 isolated `step_pulse`s → exactly 3 one-cycle `cpu_en`s, each one cycle after its pulse; `instr_cnt`=3; `mode`=00 throughout.
- Hold `run_hold` for 20 cycles starting at cycle 10 → `mode`=01 from cycle 11; `cpu_en` at cycles 15, 19, 23, 27; release → `mode`=00 and no further `cpu_en`.
- In RUN, assert `halt_pulse` in the cycle the prescaler holds 3 → no `cpu_en` next cycle, `mode`=10; with `cpu_halted`=0, a second `halt_pulse` → `mode`=00.
- `cpu_halted`=1 during RUN → HALT; a `halt_pulse` while `cpu_halted` is still 1 keeps HALT; `step_pulse` in HALT produces no `cpu_en`.
- 17 steps → `instr_cnt` sequence passes 15 → 0 → 1 (wrap).
- Assert `rst` mid-RUN while the prescaler holds 2 → all outputs reach reset values immediately; the first step after reset yields `instr_cnt`=1.
